// File: rtl/gemm_stream_host_if.sv
// Word-stream and core-side bus bundle for gemm_stream_host.
// The slave view belongs to the host block; the master view belongs to its environment.
interface gemm_stream_host_if;
    logic [31:0]  in_data;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] gemm_A;
    logic [127:0] gemm_B;
    logic [127:0] gemm_out;
    logic [31:0]  out_data;
    logic         out_valid;
    logic         out_ready;
    logic         busy;

    modport slave (
        input  in_data, in_valid, gemm_out, out_ready,
        output in_ready, gemm_A, gemm_B, out_data, out_valid, busy
    );

    modport master (
        output in_data, in_valid, gemm_out, out_ready,
        input  in_ready, gemm_A, gemm_B, out_data, out_valid, busy
    );
endinterface

// File: rtl/gemm_stream_host.sv
// Streams eight operand words into a 2x2 GEMM core, waits out its fixed
// pipeline latency, then streams the four result words back out.
module gemm_stream_host #(
    parameter int LATENCY = 6
) (
    input  logic               clk,
    input  logic               rst,
    gemm_stream_host_if.slave  bus
);

    localparam int LCNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [LCNT_W-1:0] LCNT_LAST = LCNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [2:0]          r_wcnt;
    logic [LCNT_W-1:0]   r_lcnt;
    logic [1:0]          r_rcnt;
    logic [127:0]        r_result;

    logic                w_in_hs;
    logic                w_out_hs;
    logic                w_load_done;
    logic                w_capture;
    logic                w_drain_done;
    logic [255:0]        w_ab_flat;
    logic [31:0]         w_result_word [4];

    always_comb begin
        w_state_next = r_state;
        w_in_hs      = 1'b0;
        w_out_hs     = 1'b0;
        w_load_done  = 1'b0;
        w_capture    = 1'b0;
        w_drain_done = 1'b0;
        case (r_state)
            S_LOAD: begin
                w_in_hs = bus.in_valid;
                if (w_in_hs && (r_wcnt == 3'd7)) begin
                    w_load_done  = 1'b1;
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                // Only the sample at the full latency is meaningful; earlier core
                // outputs still carry stale pipeline contents.
                if (r_lcnt == LCNT_LAST) begin
                    w_capture    = 1'b1;
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_out_hs = bus.out_ready;
                if (w_out_hs && (r_rcnt == 2'd3)) begin
                    w_drain_done = 1'b1;
                    w_state_next = S_LOAD;
                end
            end
            default: w_state_next = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_LOAD;
            r_wcnt   <= 3'd0;
            r_lcnt   <= '0;
            r_rcnt   <= 2'd0;
            r_result <= '0;
        end else begin
            r_state <= w_state_next;

            if (w_drain_done) begin
                r_wcnt <= 3'd0;
            end else if (w_in_hs) begin
                r_wcnt <= r_wcnt + 3'd1;
            end

            if (w_load_done) begin
                r_lcnt <= '0;
            end else if (r_state == S_WAIT) begin
                r_lcnt <= r_lcnt + 1'b1;
            end

            if (w_capture) begin
                r_result <= bus.gemm_out;
                r_rcnt   <= 2'd0;
            end else if (w_out_hs) begin
                r_rcnt <= r_rcnt + 2'd1;
            end
        end
    end

    // Slots 0-3 hold A, slots 4-7 hold B; each only changes on its own load handshake.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_slot
            logic [31:0] r_word;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_word <= '0;
                end else if (w_in_hs && (r_wcnt == 3'(gi))) begin
                    r_word <= bus.in_data;
                end
            end
            assign w_ab_flat[32*gi +: 32] = r_word;
        end

        for (gi = 0; gi < 4; gi++) begin : g_result
            assign w_result_word[gi] = r_result[32*gi +: 32];
        end
    endgenerate

    assign bus.gemm_A    = w_ab_flat[127:0];
    assign bus.gemm_B    = w_ab_flat[255:128];
    assign bus.in_ready  = (r_state == S_LOAD);
    assign bus.out_valid = (r_state == S_DRAIN);
    assign bus.busy      = (r_state == S_WAIT) || (r_state == S_DRAIN);
    assign bus.out_data  = (r_state == S_DRAIN) ? w_result_word[r_rcnt] : 32'd0;

endmodule

// File: tb/tb_gemm_stream_host.sv
// Directed bench for gemm_stream_host with a behavioural 2x2 GEMM core of
// matching latency driving gemm_out.
module tb_gemm_stream_host;

    localparam int LAT = 6;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    gemm_stream_host_if bus ();

    gemm_stream_host #(.LATENCY(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Core model: product registered through LAT-1 stages so that gemm_out
    // holds the matching product exactly at the LAT-th edge after the update.
    function automatic logic [127:0] matmul(input logic [127:0] a, input logic [127:0] b);
        logic [31:0] c00, c01, c10, c11;
        c00 = a[31:0]  * b[31:0]  + a[63:32]  * b[95:64];
        c01 = a[31:0]  * b[63:32] + a[63:32]  * b[127:96];
        c10 = a[95:64] * b[31:0]  + a[127:96] * b[95:64];
        c11 = a[95:64] * b[63:32] + a[127:96] * b[127:96];
        return {c11, c10, c01, c00};
    endfunction

    logic [127:0] core_pipe [LAT-1];
    always @(posedge clk) begin
        core_pipe[0] <= matmul(bus.gemm_A, bus.gemm_B);
        for (int i = 1; i < LAT - 1; i++) core_pipe[i] <= core_pipe[i-1];
    end
    assign bus.gemm_out = core_pipe[LAT-2];

    function automatic logic [255:0] mk8(input logic [31:0] a0, a1, a2, a3, b0, b1, b2, b3);
        return {b3, b2, b1, b0, a3, a2, a1, a0};
    endfunction

    task automatic send_word(input logic [31:0] w);
        bit done;
        done = 1'b0;
        bus.in_data  = w;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 100 && !done; k++) begin
            if (bus.in_ready) done = 1'b1;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        if (!done) begin
            checks++; failures++;
            $display("FAIL send_word timeout: in_ready=0 required 1");
        end
    endtask

    task automatic load8(input logic [255:0] w, input bit gaps, input bit hold_valid);
        for (int i = 0; i < 8; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
            send_word(w[32*i +: 32]);
        end
        if (hold_valid) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 32'hDEADBEEF;
        end
    endtask

    // mode 0: out_ready always high; 1: backpressure pattern; 2: as 0 but in_valid kept high
    task automatic drain4(input logic [127:0] exp, input int mode, input string name);
        int  cyc, seen, idx;
        bit  hs;
        cyc = 0; seen = -1; idx = 0;
        while (idx < 4 && cyc < 200) begin
            if (bus.out_valid) begin
                if (seen < 0) seen = cyc;
                checks++;
                if (bus.out_data !== exp[32*idx +: 32]) begin
                    failures++;
                    $display("FAIL %s out_data word%0d: got %h required %h", name, idx, bus.out_data, exp[32*idx +: 32]);
                end
                checks++;
                if (bus.in_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL %s in_ready during drain: got %b required 0", name, bus.in_ready);
                end
                if (mode == 1) bus.out_ready = (cyc - seen >= 5) && (((cyc - seen - 5) % 2) == 0);
                else           bus.out_ready = 1'b1;
            end else begin
                checks++;
                if (bus.busy !== 1'b1) begin
                    failures++;
                    $display("FAIL %s busy while waiting: got %b required 1", name, bus.busy);
                end
                bus.out_ready = (mode == 1) ? 1'b0 : 1'b1;
            end
            hs = bus.out_valid && bus.out_ready;
            @(posedge clk); #1;
            cyc++;
            if (hs) idx++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        if (idx < 4) begin
            checks++; failures++;
            $display("FAIL %s drain timeout: got %0d words required 4", name, idx);
        end
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL %s post-drain: out_valid=%b in_ready=%b busy=%b required 0 1 0", name, bus.out_valid, bus.in_ready, bus.busy);
        end
        $display("txn %s: %0d words drained in %0d cycles", name, idx, cyc);
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.out_data !== 32'd0) begin
            failures++;
            $display("FAIL reset outputs: in_ready=%b out_valid=%b busy=%b out_data=%h required 1 0 0 0", bus.in_ready, bus.out_valid, bus.busy, bus.out_data);
        end
        checks++;
        if (bus.gemm_A !== 128'd0 || bus.gemm_B !== 128'd0) begin
            failures++;
            $display("FAIL reset buses: gemm_A=%h gemm_B=%h required 0", bus.gemm_A, bus.gemm_B);
        end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_identity();
        load8(mk8(1, 0, 0, 1, 5, 6, 7, 8), 1'b0, 1'b0);
        checks++;
        if (bus.gemm_A !== {32'd1, 32'd0, 32'd0, 32'd1} || bus.gemm_B !== {32'd8, 32'd7, 32'd6, 32'd5}) begin
            failures++;
            $display("FAIL identity packing: gemm_A=%h gemm_B=%h", bus.gemm_A, bus.gemm_B);
        end
        for (int k = 0; k <= LAT; k++) begin
            checks++;
            if (bus.out_valid !== (k == LAT)) begin
                failures++;
                $display("FAIL identity latency at T+%0d: out_valid=%b required %b", k, bus.out_valid, (k == LAT));
            end
            if (k < LAT) begin @(posedge clk); #1; end
        end
        drain4({32'd8, 32'd7, 32'd6, 32'd5}, 0, "identity");
    endtask

    task automatic test_general();
        load8(mk8(1, 2, 3, 4, 5, 6, 7, 8), 1'b0, 1'b0);
        drain4({32'd50, 32'd43, 32'd22, 32'd19}, 0, "general");
    endtask

    task automatic test_wrap();
        load8(mk8(32'h80000000, 0, 0, 0, 2, 3, 0, 0), 1'b0, 1'b0);
        drain4({32'd0, 32'd0, 32'h80000000, 32'd0}, 0, "wrap");
    endtask

    task automatic test_backpressure();
        load8(mk8(2, 0, 0, 2, 1, 2, 3, 4), 1'b0, 1'b0);
        drain4({32'd8, 32'd6, 32'd4, 32'd2}, 1, "backpressure");
    endtask

    task automatic test_reset_mid_load();
        for (int i = 0; i < 5; i++) send_word(32'h1000 + i);
        rst = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.gemm_A !== 128'd0) begin
            failures++;
            $display("FAIL mid-load reset: in_ready=%b out_valid=%b busy=%b gemm_A=%h required 1 0 0 0", bus.in_ready, bus.out_valid, bus.busy, bus.gemm_A);
        end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        load8(mk8(1, 2, 3, 4, 5, 6, 7, 8), 1'b0, 1'b0);
        drain4({32'd50, 32'd43, 32'd22, 32'd19}, 0, "reset_mid_load");
    endtask

    task automatic test_back_to_back();
        load8(mk8(2, 0, 0, 3, 1, 2, 3, 4), 1'b1, 1'b1);
        drain4({32'd12, 32'd9, 32'd4, 32'd2}, 2, "b2b_first");
        checks++;
        if (bus.gemm_A !== {32'd3, 32'd0, 32'd0, 32'd2} || bus.gemm_B !== {32'd4, 32'd3, 32'd2, 32'd1}) begin
            failures++;
            $display("FAIL b2b buses held: gemm_A=%h gemm_B=%h", bus.gemm_A, bus.gemm_B);
        end
        load8(mk8(1, 1, 1, 1, 1, 2, 3, 4), 1'b1, 1'b1);
        drain4({32'd6, 32'd4, 32'd6, 32'd4}, 2, "b2b_second");
        checks++;
        if (bus.gemm_A !== {32'd1, 32'd1, 32'd1, 32'd1} || bus.gemm_B !== {32'd4, 32'd3, 32'd2, 32'd1}) begin
            failures++;
            $display("FAIL b2b second buses held: gemm_A=%h gemm_B=%h", bus.gemm_A, bus.gemm_B);
        end
    endtask

    initial begin
        bus.in_data   = 32'd0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        test_reset();
        test_identity();
        test_general();
        test_wrap();
        test_backpressure();
        test_reset_mid_load();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
